// File: rtl/zjh_cnt_pkg.sv
// Shared types and constants for the zjh_cnt_seq modulo-N counter sequencer.
package zjh_cnt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  // Shortest run that has a distinct start and terminal count.
  localparam int MIN_MODULUS = 2;

endpackage

// File: rtl/zjh_cnt4_slice.sv
// Behavioural 74HC161 equivalent: 4-bit synchronous counter with
// synchronous active-high reset, synchronous active-low parallel load.
module zjh_cnt4_slice (
  input  logic       Clk,
  input  logic       MR,
  input  logic       Cep,
  input  logic       Cet,
  input  logic       PE,
  input  logic [3:0] D,
  output logic [3:0] Q,
  output logic       TC
);

  always_ff @(posedge Clk) begin
    if (MR) begin
      Q <= 4'd0;
    end else if (!PE) begin
      Q <= D;
    end else if (Cep && Cet) begin
      Q <= Q + 4'd1;
    end
  end

  // Carry out ignores Cep, as on the real part, so the chain ripples on Cet.
  assign TC = Cet && (Q == 4'hF);

endmodule

// File: rtl/zjh_cnt_seq.sv
// Start/stop/done sequencer for a cascade of 4-bit counter slices forming a
// programmable modulo-N timer. Optional Pause input under ZJH_CNT_SEQ_PAUSE_EN.
module zjh_cnt_seq
  import zjh_cnt_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             MR,
  input  logic             Start,
  input  logic             Stop,
  input  logic             Mode,
  input  logic [WIDTH-1:0] Modulus,
`ifdef ZJH_CNT_SEQ_PAUSE_EN
  input  logic             Pause,
`endif
  output logic             Busy,
  output logic             Done,
  output logic             Tick,
  output logic             Err,
  output logic [WIDTH-1:0] Count
);

  localparam int NSLICE = WIDTH / 4;
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MIN_MOD = WIDTH'(MIN_MODULUS);

  state_t             state;
  logic [WIDTH-1:0]   mod_reg;
  logic               mode_reg;
  logic               err_r;

  logic               pause;
  logic               terminal;
  logic               wrap;
  logic               pe;
  logic               cep;
  logic [NSLICE-1:0]  cet;
  logic [NSLICE-1:0]  tc;
  logic               unused_tc;

`ifdef ZJH_CNT_SEQ_PAUSE_EN
  assign pause = Pause;
`else
  assign pause = 1'b0;
`endif

  // Terminal decode replaces the old AND-gate + inverter feeding PE.
  assign terminal = (state == ST_RUN) && (Count == mod_reg - ONE);
  assign wrap     = terminal && !pause;

  // Any non-RUN state, an abort, or the terminal edge loads zero.
  assign pe  = (state == ST_RUN) && !Stop && !wrap;
  assign cep = !pause;

  assign Busy = (state == ST_RUN);
  assign Done = (state == ST_DONE);
  assign Tick = wrap;
  assign Err  = err_r;

  // The top slice's carry has no consumer: Count never reaches all-ones.
  assign unused_tc = tc[NSLICE-1];

  for (genvar k = 0; k < NSLICE; k++) begin : g_slice
    if (k == 0) begin : g_first
      assign cet[k] = 1'b1;
    end else begin : g_rest
      assign cet[k] = tc[k-1];
    end

    zjh_cnt4_slice u_slice (
      .Clk (Clk),
      .MR  (MR),
      .Cep (cep),
      .Cet (cet[k]),
      .PE  (pe),
      .D   (4'd0),
      .Q   (Count[4*k +: 4]),
      .TC  (tc[k])
    );
  end

  always_ff @(posedge Clk) begin
    if (MR) begin
      state    <= ST_IDLE;
      mod_reg  <= '0;
      mode_reg <= MODE_ONESHOT;
      err_r    <= 1'b0;
    end else begin
      err_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Start) begin
            if (Modulus < MIN_MOD) begin
              err_r <= 1'b1;
            end else begin
              mod_reg  <= Modulus;
              mode_reg <= Mode;
              state    <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (Stop) begin
            state <= ST_IDLE;
          end else if (wrap && (mode_reg != MODE_PERIODIC)) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zjh_cnt_seq.sv
// Scoreboard bench for zjh_cnt_seq: stimulus queues expected Tick/Done/Err
// events, a negedge monitor pops and compares them as the DUT emits them.
module tb_zjh_cnt_seq;

  localparam int W = 8;
  localparam int EV_TICK = 0;
  localparam int EV_DONE = 1;
  localparam int EV_ERR  = 2;

  typedef struct {
    int kind;
    int cyc;
    int count;
  } ev_t;

  logic         Clk = 1'b0;
  logic         MR = 1'b1;
  logic         Start = 1'b0;
  logic         Stop = 1'b0;
  logic         Mode = 1'b0;
  logic [W-1:0] Modulus = '0;
`ifdef ZJH_CNT_SEQ_PAUSE_EN
  logic         Pause = 1'b0;
`endif
  logic         Busy, Done, Tick, Err;
  logic [W-1:0] Count;

  int  cyc = 0;
  int  tests = 0;
  int  fails = 0;
  ev_t exp_q[$];

  zjh_cnt_seq #(.WIDTH(W)) dut (
    .Clk     (Clk),
    .MR      (MR),
    .Start   (Start),
    .Stop    (Stop),
    .Mode    (Mode),
    .Modulus (Modulus),
`ifdef ZJH_CNT_SEQ_PAUSE_EN
    .Pause   (Pause),
`endif
    .Busy    (Busy),
    .Done    (Done),
    .Tick    (Tick),
    .Err     (Err),
    .Count   (Count)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  function automatic void chk(string name, longint act, longint expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  function automatic void push(int kind, int c, int count);
    ev_t e;
    e.kind = kind;
    e.cyc = c;
    e.count = count;
    exp_q.push_back(e);
  endfunction

  // Monitor: every emitted event must match the head of the queue.
  always @(negedge Clk) begin
    if (Tick || Done || Err) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event_tde", {29'd0, Tick, Done, Err}, 0);
      end else begin
        ev_t e;
        int  k;
        e = exp_q.pop_front();
        k = Tick ? EV_TICK : (Done ? EV_DONE : EV_ERR);
        chk("event_kind", k, e.kind);
        chk("event_cycle", cyc, e.cyc);
        chk("event_count", Count, e.count);
        if (k == EV_DONE) chk("busy_low_in_done", Busy, 0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_until(int t);
    while (cyc < t) step();
  endtask

  // Drives Start for one edge; k is the first cycle spent in RUN.
  task automatic start_run(int m, logic md, output int k);
    Start = 1'b1;
    Modulus = W'(m);
    Mode = md;
    k = cyc + 1;
    step();
    Start = 1'b0;
  endtask

  initial begin
    int k;
    int p;

    // Reset then idle
    step();
    step();
    chk("reset_count", Count, 0);
    chk("reset_busy", Busy, 0);
    chk("reset_done", Done, 0);
    chk("reset_tick", Tick, 0);
    chk("reset_err", Err, 0);
    MR = 1'b0;
    repeat (10) step();
    chk("idle_count", Count, 0);
    chk("idle_busy", Busy, 0);

    // One-shot N=14
    start_run(14, 1'b0, k);
    push(EV_TICK, k + 13, 13);
    push(EV_DONE, k + 14, 0);
    chk("oneshot_busy_first", Busy, 1);
    chk("oneshot_count_first", Count, 0);
    wait_until(k + 13);
    chk("oneshot_busy_last", Busy, 1);
    chk("oneshot_count_last", Count, 13);
    wait_until(k + 15);
    chk("oneshot_back_idle", Busy, 0);
    chk("oneshot_idle_count", Count, 0);
    repeat (3) step();

    // Minimum legal modulus N=2
    start_run(2, 1'b0, k);
    push(EV_TICK, k + 1, 1);
    push(EV_DONE, k + 2, 0);
    wait_until(k + 4);

    // Periodic N=200, five periods
    start_run(200, 1'b1, k);
    for (int i = 0; i < 5; i++) push(EV_TICK, k + 199 + 200 * i, 199);
    wait_until(k + 15);
    chk("carry_pre_15", Count, 15);
    step();
    chk("carry_16", Count, 16);
    wait_until(k + 191);
    chk("carry_pre_191", Count, 191);
    step();
    chk("carry_192", Count, 192);
    wait_until(k + 200);
    chk("periodic_wrap", Count, 0);
    chk("periodic_busy", Busy, 1);
    wait_until(k + 1000);
    chk("periodic_after5", Count, 0);
    Stop = 1'b1;
    step();
    Stop = 1'b0;
    chk("periodic_stop_busy", Busy, 0);
    repeat (3) step();

    // Stop at Count=7
    start_run(14, 1'b0, k);
    wait_until(k + 7);
    chk("stop_at_7_pre", Count, 7);
    Stop = 1'b1;
    step();
    Stop = 1'b0;
    chk("stop_count", Count, 0);
    chk("stop_busy", Busy, 0);
    repeat (20) step();
    chk("stop_stays_idle", Count, 0);

    // Rejected starts
    p = cyc;
    Start = 1'b1;
    Modulus = W'(1);
    push(EV_ERR, p + 1, 0);
    step();
    Start = 1'b0;
    chk("err1_busy", Busy, 0);
    step();
    Start = 1'b1;
    Modulus = W'(0);
    push(EV_ERR, cyc + 1, 0);
    step();
    Start = 1'b0;
    chk("err0_busy", Busy, 0);
    repeat (3) step();

    // Stop coincident with Tick
    start_run(14, 1'b0, k);
    push(EV_TICK, k + 13, 13);
    wait_until(k + 13);
    Stop = 1'b1;
    step();
    Stop = 1'b0;
    chk("stoptick_busy", Busy, 0);
    chk("stoptick_count", Count, 0);
    repeat (5) step();

    // Reset mid-run
    start_run(200, 1'b1, k);
    wait_until(k + 100);
    chk("mr_pre_count", Count, 100);
    MR = 1'b1;
    step();
    MR = 1'b0;
    chk("mr_count", Count, 0);
    chk("mr_busy", Busy, 0);
    repeat (5) step();
    chk("mr_idle_count", Count, 0);

    // Start and Mode/Modulus changes during RUN are ignored
    start_run(20, 1'b1, k);
    push(EV_TICK, k + 19, 19);
    push(EV_TICK, k + 39, 19);
    push(EV_TICK, k + 59, 19);
    wait_until(k + 5);
    Start = 1'b1;
    Modulus = W'(7);
    Mode = 1'b0;
    step();
    Start = 1'b0;
    Modulus = W'(3);
    wait_until(k + 60);
    chk("ignored_wrap_count", Count, 0);
    Stop = 1'b1;
    step();
    Stop = 1'b0;
    chk("ignored_stop_busy", Busy, 0);
    repeat (3) step();

    // Top-of-range modulus: counts to 254 without touching 255
    start_run(255, 1'b0, k);
    push(EV_TICK, k + 254, 254);
    push(EV_DONE, k + 255, 0);
    wait_until(k + 257);

`ifdef ZJH_CNT_SEQ_PAUSE_EN
    // Pause five cycles at Count=3 (N=10): Done five cycles late
    start_run(10, 1'b0, k);
    push(EV_TICK, k + 14, 9);
    push(EV_DONE, k + 15, 0);
    wait_until(k + 3);
    Pause = 1'b1;
    repeat (2) step();
    chk("pause_hold_a", Count, 3);
    repeat (3) step();
    chk("pause_hold_b", Count, 3);
    chk("pause_busy", Busy, 1);
    Pause = 1'b0;
    step();
    chk("pause_resume", Count, 4);
    wait_until(k + 17);

    // Pause at terminal: Tick suppressed until release
    start_run(10, 1'b0, k);
    push(EV_TICK, k + 12, 9);
    push(EV_DONE, k + 13, 0);
    wait_until(k + 9);
    Pause = 1'b1;
    repeat (2) step();
    chk("pause_term_hold", Count, 9);
    chk("pause_term_busy", Busy, 1);
    step();
    Pause = 1'b0;
    wait_until(k + 15);
`endif

    repeat (3) step();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/zjh_cnt_seq.md
Name: zjh_cnt_seq

Overview:
- Sequencer/controller for the cascaded 74HC161-style counter datapath.
- Builds a programmable modulo-N timer/divider from 4-bit counter slices. The chain is fed Cep/Cet/PE/D, and wrap-around is decided from Q against a captured modulus.
- Replaces the hard-wired AND-decode + inverter-into-PE modulus scheme. Provides a start/stop/done handshake and one-shot or periodic operation for the system tick and timing chains.

Parameters:
- WIDTH, 8, counter width in bits; must be a multiple of 4 and ≥ 4.
- NSLICE, WIDTH/4, number of 4-bit slices (derived; not overridden).

Ports:
- Clk  in  1  system clock, rising edge
- MR  in  1  reset; Clk has one clock domain; reset is synchronous and active-high
- Start  in  1  start request, sampled in IDLE only
- Stop  in  1  abort request, sampled in RUN only
- Mode  in  1  0 = one-shot, 1 = periodic; captured with Start
- Modulus  in  WIDTH  count length N; captured with Start
- Busy  out  1  high while in RUN
- Done  out  1  one-cycle pulse at end of a one-shot run
- Tick  out  1  high in the cycle Count == N-1 (terminal)
- Err  out  1  one-cycle pulse: Start rejected because Modulus < 2
- Count  out  WIDTH  current counter value (slice Q outputs concatenated, slice 0 = LSBs)

Behaviour:
- Reset (MR=1 at an edge): state IDLE, Count=0, mod_reg=0, mode_reg=0. Busy, Done, Tick and Err are all 0. MR has priority over every other input.
- States: IDLE, RUN, DONE.
- IDLE:
  - Count held at 0 (slices loaded with D=0).
  - Start=1 with Modulus ≥ 2: capture mod_reg=Modulus and mode_reg=Mode, then go to RUN.
  - Start=1 with Modulus < 2: Err=1 next cycle, stay in IDLE.
- RUN:
  - Slice 0 has Cep=Cet=1. Slice k has Cet = TC of slice k-1, i.e. a synchronous ripple enable.
  - Terminal: Tick=1 combinationally while Count == mod_reg-1.
  - At the terminal edge all slices take PE=0, D=0, so Count returns to 0.
  - At the terminal edge, mode_reg=1 stays in RUN; mode_reg=0 goes to DONE.
- DONE: Done=1 and Busy=0 for exactly one cycle, Count=0, then go to IDLE.
- Latency: Start sampled at edge k puts Count=0 in cycle k+1. Tick occurs in cycle k+N. In one-shot mode Done occurs in cycle k+N+1. Period is exactly N cycles.
- Stop in RUN: next cycle is IDLE with Count=0, and no Done is issued. Stop beats terminal when both occur in the same cycle; Tick is still shown that cycle.
- Start while in RUN or DONE is ignored. Modulus/Mode changes during RUN have no effect.
- Modulus=2^WIDTH-1 is legal. Count never reaches 2^WIDTH-1, so the slice TC of the top slice is unused.
- MR mid-run: immediate return to the reset values on that edge, and no Done.

Optional Feature:
- Macro: ZJH_CNT_SEQ_PAUSE_EN.
- Defined:
  - Adds input Pause (1 bit).
  - While Pause=1 in RUN, slice 0 has Cep=0 and Count holds.
  - Tick is gated by !Pause.
  - Terminal reload and state transitions are suppressed while paused.
  - Stop still overrides Pause.
- Undefined: no Pause port; counting is unconditional in RUN.

Decomposition:
- Package zjh_cnt_pkg holds:
  - state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - MODE_ONESHOT/MODE_PERIODIC constants;
  - the MIN_MODULUS=2 constant.
- Sub-module zjh_cnt4_slice: behavioural 74HC161 equivalent.
  - Ports: Clk, MR, Cep, Cet, PE, D[3:0], Q[3:0], TC.
  - Reset is synchronous active-high, and load is synchronous active-low.
  - Instantiated NSLICE times via generate.

Test Plan:
- Reset then idle: MR=1 for 2 cycles → Count=0, all flags 0; Start=0 for 10 cycles → Count stays 0.
- One-shot N=14: Start pulse with Modulus=14, Mode=0 → Count runs 0..13; Tick in the Count=13 cycle; Done exactly one cycle later; Busy high for 14 cycles; back to IDLE.
- Periodic N=200: Start with Mode=1 → Tick every 200 cycles for 5 periods; slice-1 carries at counts 15→16 and 191→192 are correct; no Done.
- Abort and reject:
  - Stop at Count=7 (N=14) → next cycle IDLE, Count=0, no Done.
  - Start with Modulus=1 → Err pulse, Busy stays 0.
  - Stop coincident with Tick → IDLE, no Done.
- Reset mid-run plus ignored inputs:
  - MR at Count=100 (N=200, periodic) → Count=0 and IDLE next cycle.
  - Start during RUN with a new Modulus → period unchanged.
- PAUSE_EN build:
  - Pause for 5 cycles at Count=3 (N=10) → Count holds at 3, and Done arrives 5 cycles later than unpaused.
  - Pause asserted at Count=9 → Tick suppressed until release.
